div_ctrl: RTL and testbench

Sequencer between the EX stage and the iterative 32-bit divider. Accepts a DIV/DIVU request from EX, holds operands stable, drives the divider's start/annul handshake, stalls the pipeline until the result returns, and issues a single HI/LO write. Handles flush mid-divide, divide-by-zero and a watchdog timeout.

---
 rtl/div_ctrl_if.sv | 32 +++
 rtl/div_ctrl.sv | 67 ++++++
 tb/tb_div_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX-side request/result and divider-side handshake bundle for div_ctrl.
interface div_ctrl_if;
    logic        div_req_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        flush_i;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic        div_signed_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        stallreq_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;
    logic        timeout_err_o;

    modport master (
        output div_req_i, signed_i, opdata1_i, opdata2_i, flush_i, div_result_i, div_ready_i,
        input  div_opdata1_o, div_opdata2_o, div_signed_o, div_start_o, div_annul_o,
               stallreq_o, hi_o, lo_o, whilo_o, timeout_err_o
    );

    modport slave (
        input  div_req_i, signed_i, opdata1_i, opdata2_i, flush_i, div_result_i, div_ready_i,
        output div_opdata1_o, div_opdata2_o, div_signed_o, div_start_o, div_annul_o,
               stallreq_o, hi_o, lo_o, whilo_o, timeout_err_o
    );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: sequences one DIV/DIVU through the iterative divider, stalling EX until a single HI/LO write.
module div_ctrl #(
    parameter int TIMEOUT = 63
) (
    input logic      clk,
    input logic      rst,
    div_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    state_t     state, state_nx;
    logic [7:0] cnt;
    logic       accept, cap, to_hit;

    always_comb begin
        state_nx = state;
        to_hit   = 1'b0;
        cap      = 1'b0;
        accept   = rst && state == IDLE && bus.div_req_i && !bus.flush_i;
        case (state)
            IDLE: state_nx = accept ? BUSY : IDLE;
            BUSY: begin
                // flush beats the watchdog, which beats a returning result
                to_hit   = !bus.flush_i && (cnt + 8'd1 == 8'(TIMEOUT));
                cap      = !bus.flush_i && !to_hit && bus.div_ready_i;
                state_nx = (bus.flush_i || to_hit) ? DRAIN : cap ? DONE : BUSY;
            end
            DONE:    state_nx = IDLE;
            DRAIN:   state_nx = cnt[0] ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.stallreq_o = accept || state == BUSY;
    assign bus.whilo_o    = state == DONE && !bus.flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            cnt               <= 8'd0;
            bus.div_opdata1_o <= 32'd0;
            bus.div_opdata2_o <= 32'd0;
            bus.div_signed_o  <= 1'b0;
            bus.div_start_o   <= 1'b0;
            bus.div_annul_o   <= 1'b0;
            bus.hi_o          <= 32'd0;
            bus.lo_o          <= 32'd0;
            bus.timeout_err_o <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= (state_nx == state && state != IDLE) ? cnt + 8'd1 : 8'd0;
            bus.div_start_o <= state_nx == BUSY;
            bus.div_annul_o <= state_nx == DRAIN;
            if (accept) begin
                bus.div_opdata1_o <= bus.opdata1_i;
                bus.div_opdata2_o <= bus.opdata2_i;
                bus.div_signed_o  <= bus.signed_i;
            end
            if (cap) begin
                bus.hi_o <= bus.div_result_i[63:32];
                bus.lo_o <= bus.div_result_i[31:0];
            end
            if (to_hit)
                bus.timeout_err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: table-driven and randomized checks of div_ctrl against a cycle-timeline reference model.
module tb_div_ctrl;
    localparam int TIMEOUT = 63;

    logic clk = 1'b0;
    logic rst;
    div_ctrl_if bus();

    div_ctrl #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;
    bit          exp_terr = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        int          flush_at;
        bit          hold;
        bit          never;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          ewr;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
        else passed++;
    endtask

    task automatic idle_inputs();
        bus.div_req_i    = 1'b0;
        bus.signed_i     = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.flush_i      = 1'b0;
        bus.div_ready_i  = 1'b0;
        bus.div_result_i = 64'd0;
    endtask

    task automatic chk_all_zero(input string n);
        chk(n, {bus.div_opdata1_o, bus.div_opdata2_o, bus.hi_o},
               96'd0);
        chk({n, "_ctl"}, {bus.lo_o, bus.div_signed_o, bus.div_start_o, bus.div_annul_o,
                          bus.stallreq_o, bus.whilo_o, bus.timeout_err_o}, 96'd0);
    endtask

    // One divide: the expected outputs per cycle follow from when the divide ends
    // (ready, watchdog or flush) and what kind of ending it was.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b0, input logic sgn,
                           input int flush_at, input bit hold, input bit never, output int wr);
        logic [31:0] b, q, r;
        int lat, e, kind, last;
        bit dflush;
        b = b0;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        lat  = never ? 1000 : (b == 32'd0 ? 4 : 36);
        e    = lat;
        kind = 0;
        if (TIMEOUT <= e) begin
            e    = TIMEOUT;
            kind = 1;
        end
        if (flush_at >= 1 && flush_at <= e) begin
            e    = flush_at;
            kind = 2;
        end
        dflush = kind == 0 && flush_at == e + 1;
        last   = kind == 0 ? e + 1 : e + 2;
        wr     = 0;
        for (int k = 0; k <= last + 1; k++) begin
            @(posedge clk);
            #2;
            bus.div_req_i    = k <= e || (hold && k == e + 1);
            bus.opdata1_i    = k == 0 ? a : $urandom;
            bus.opdata2_i    = k == 0 ? b : $urandom;
            bus.signed_i     = k == 0 ? sgn : 1'($urandom);
            bus.flush_i      = k == flush_at;
            bus.div_ready_i  = k == lat && k <= e;
            bus.div_result_i = bus.div_ready_i ? {r, q} : {$urandom, $urandom};
            #2;
            if (kind == 0 && k == e + 1) begin
                cur_hi = r;
                cur_lo = q;
            end
            if (kind == 1 && k == e + 1) exp_terr = 1'b1;
            chk("ctrl", {bus.stallreq_o, bus.div_start_o, bus.div_annul_o, bus.whilo_o, bus.timeout_err_o},
                {k <= e, k >= 1 && k <= e, kind != 0 && (k == e + 1 || k == e + 2),
                 kind == 0 && k == e + 1 && !dflush, exp_terr});
            chk("hilo", {bus.hi_o, bus.lo_o}, {cur_hi, cur_lo});
            if (k >= 1 && k <= e)
                chk("ops", {bus.div_opdata1_o, bus.div_opdata2_o, bus.div_signed_o}, {a, b, sgn});
            wr += int'(bus.whilo_o);
        end
        idle_inputs();
    endtask

    initial begin
        int wr;
        tbl[0] = '{32'd100,        32'd7,  1'b0, -1, 1'b0, 1'b0, 32'd2,          32'd14,         1};
        tbl[1] = '{32'hFFFF_FF9C,  32'd7,  1'b1, -1, 1'b0, 1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFF2,  1};
        tbl[2] = '{32'd5,          32'd0,  1'b0, -1, 1'b0, 1'b0, 32'd0,          32'd0,          1};
        tbl[3] = '{32'd100,        32'd7,  1'b0, 10, 1'b0, 1'b0, 32'd0,          32'd0,          0};
        tbl[4] = '{32'd9,          32'd3,  1'b0, -1, 1'b0, 1'b0, 32'd0,          32'd3,          1};
        tbl[5] = '{32'd1000,       32'd3,  1'b0, 36, 1'b0, 1'b0, 32'd0,          32'd3,          0};
        tbl[6] = '{32'd50,         32'd5,  1'b0, 37, 1'b0, 1'b0, 32'd0,          32'd10,         0};
        tbl[7] = '{32'd77,         32'd10, 1'b0, -1, 1'b1, 1'b0, 32'd7,          32'd7,          1};
        tbl[8] = '{32'd1,          32'd1,  1'b0, -1, 1'b0, 1'b1, 32'd7,          32'd7,          0};

        rst = 1'b0;
        idle_inputs();
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #2 rst = 1'b1;

        foreach (tbl[i]) begin
            run_div(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].flush_at, tbl[i].hold, tbl[i].never, wr);
            chk($sformatf("row%0d_wr", i), 96'(wr), 96'(tbl[i].ewr));
            chk($sformatf("row%0d_res", i), {bus.hi_o, bus.lo_o}, {tbl[i].ehi, tbl[i].elo});
        end

        // asynchronous reset in the middle of BUSY, with the watchdog flag still set
        @(posedge clk);
        #2;
        bus.div_req_i = 1'b1;
        bus.opdata1_i = 32'd1234;
        bus.opdata2_i = 32'd11;
        bus.signed_i  = 1'b1;
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.div_req_i = 1'b0;
        @(posedge clk);
        #2;
        chk_all_zero("post_rst");
        cur_hi   = 32'd0;
        cur_lo   = 32'd0;
        exp_terr = 1'b0;

        for (int n = 0; n < 30; n++) begin
            logic [31:0] a, b;
            int fa;
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
            fa = ($urandom_range(0, 9) < 7) ? -1 : $urandom_range(1, 40);
            run_div(a, b, 1'($urandom), fa, 1'($urandom), 1'b0, wr);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
